// File: rtl/trade_pkg.sv
// Shared types and constants for the trading board's order path.
package trade_pkg;

  localparam int PRICE_W           = 8;
  localparam int PRICE_MAX_DEFAULT = 99;

  // Bit positions of the keys inside the per-key vectors
  localparam int KEY_BUY    = 0;
  localparam int KEY_SELL   = 1;
  localparam int KEY_CANCEL = 2;
  localparam int NUM_KEYS   = 3;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    OE_IDLE   = 2'd0,
    OE_COMMIT = 2'd1,
    OE_HOLD   = 2'd2
  } oe_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counting debouncer for one active-low pushbutton.
// press_o pulses in the cycle whose edge moves the debounced level from 1 to 0.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             settle;

  // The sample present now is the last of the required run of differing samples
  assign settle = (sync2_q != level_q) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (settle) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = settle & level_q;

endmodule

// File: rtl/order_entry.sv
// Order-entry front end: debounced keys and synchronised switch price become
// one resting buy and one resting sell order, consumed by the matcher.
module order_entry
  import trade_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRICE_MAX       = PRICE_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRICE_W-1:0] sw,
  input  logic               key_buy,
  input  logic               key_sell,
  input  logic               key_cancel,
  input  logic               halt_signal,
  input  logic               match_signal,
  output logic [PRICE_W-1:0] buy_price,
  output logic [PRICE_W-1:0] sell_price,
  output logic               buy_valid,
  output logic               sell_valid,
  output logic               order_strobe,
  output logic               order_side,
  output logic               reject
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;

  assign key_raw = {key_cancel, key_sell, key_buy};

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_raw[gi]),
        .level_o (key_level[gi]),
        .press_o (key_press[gi])
      );
    end
  endgenerate

  logic [PRICE_W-1:0] sw_sync1_q;
  logic [PRICE_W-1:0] sw_sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= sw;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  oe_state_e           state_q;
  logic [NUM_KEYS-1:0] events_q;
  logic [PRICE_W-1:0]  entry_price_q;
  logic [PRICE_W-1:0]  buy_price_q;
  logic [PRICE_W-1:0]  sell_price_q;
  logic                buy_valid_q;
  logic                sell_valid_q;
  logic                strobe_q;
  side_e               side_q;
  logic                reject_q;
  logic                price_bad;

  assign price_bad = int'(entry_price_q) > PRICE_MAX;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= OE_IDLE;
      events_q      <= '0;
      entry_price_q <= '0;
      buy_price_q   <= '0;
      sell_price_q  <= '0;
      buy_valid_q   <= 1'b0;
      sell_valid_q  <= 1'b0;
      strobe_q      <= 1'b0;
      side_q        <= SIDE_BUY;
      reject_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      reject_q <= 1'b0;

      // A commit below overrides this clear for its own side
      if (match_signal) begin
        buy_valid_q  <= 1'b0;
        sell_valid_q <= 1'b0;
      end

      case (state_q)
        OE_IDLE: begin
          if (|key_press) begin
            events_q      <= key_press;
            entry_price_q <= sw_sync2_q;
            state_q       <= OE_COMMIT;
          end
        end

        OE_COMMIT: begin
          state_q <= OE_HOLD;
          if (events_q[KEY_CANCEL]) begin
            buy_valid_q  <= 1'b0;
            sell_valid_q <= 1'b0;
          end else if (events_q[KEY_BUY] && events_q[KEY_SELL]) begin
            reject_q <= 1'b1;
          end else if (halt_signal || price_bad) begin
            reject_q <= 1'b1;
          end else if (events_q[KEY_BUY]) begin
            buy_price_q <= entry_price_q;
            buy_valid_q <= 1'b1;
            strobe_q    <= 1'b1;
            side_q      <= SIDE_BUY;
          end else begin
            sell_price_q <= entry_price_q;
            sell_valid_q <= 1'b1;
            strobe_q     <= 1'b1;
            side_q       <= SIDE_SELL;
          end
        end

        OE_HOLD: begin
          if (&key_level) begin
            state_q <= OE_IDLE;
          end
        end

        default: state_q <= OE_IDLE;
      endcase
    end
  end

  assign buy_price    = buy_price_q;
  assign sell_price   = sell_price_q;
  assign buy_valid    = buy_valid_q;
  assign sell_valid   = sell_valid_q;
  assign order_strobe = strobe_q;
  assign order_side   = side_q;
  assign reject       = reject_q;

endmodule

// File: tb/tb_order_entry.sv
// Self-checking bench for order_entry with DEBOUNCE_CYCLES = 4: a vector table,
// hand-written corner sequences and a randomized run against a book model.
module tb_order_entry;

  localparam int DEB = 4;
  localparam int EXP_EDGE = DEB + 3;  // edge index (E counted as 1) of strobe/reject

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic       key_buy, key_sell, key_cancel;
  logic       halt_signal, match_signal;
  logic [7:0] buy_price, sell_price;
  logic       buy_valid, sell_valid, order_strobe, order_side, reject;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  order_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .PRICE_MAX(99)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .key_buy      (key_buy),
    .key_sell     (key_sell),
    .key_cancel   (key_cancel),
    .halt_signal  (halt_signal),
    .match_signal (match_signal),
    .buy_price    (buy_price),
    .sell_price   (sell_price),
    .buy_valid    (buy_valid),
    .sell_valid   (sell_valid),
    .order_strobe (order_strobe),
    .order_side   (order_side),
    .reject       (reject)
  );

  typedef struct {
    logic [2:0] keys;   // bit0 buy, bit1 sell, bit2 cancel
    logic [7:0] price;
    logic       halt;
    logic       match;
    logic       e_strobe;
    logic       e_reject;
    logic       e_side;
    logic       e_bv;
    logic       e_sv;
    logic [7:0] e_bp;
    logic [7:0] e_sp;
  } vec_t;

  vec_t vecs[12];

  // Reference book for the randomized run
  logic       m_bv, m_sv;
  logic [7:0] m_bp, m_sp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_buy_price"}, 32'(buy_price), 32'd0);
    check({tag, "_sell_price"}, 32'(sell_price), 32'd0);
    check({tag, "_buy_valid"}, 32'(buy_valid), 32'd0);
    check({tag, "_sell_valid"}, 32'(sell_valid), 32'd0);
    check({tag, "_strobe"}, 32'(order_strobe), 32'd0);
    check({tag, "_side"}, 32'(order_side), 32'd0);
    check({tag, "_reject"}, 32'(reject), 32'd0);
  endtask

  // Press the given keys cleanly, observe a 12-edge window, then release and settle.
  task automatic run_entry(input logic [2:0] keys, input logic [7:0] price,
                           input logic halt, input logic match, input logic [7:0] sw_after,
                           output int st_cnt, output int st_first,
                           output int rj_cnt, output int rj_first, output logic side_seen);
    st_cnt = 0; st_first = -1; rj_cnt = 0; rj_first = -1; side_seen = 1'b0;
    @(posedge clk); #1;
    sw = price;
    halt_signal = halt;
    key_buy = ~keys[0];
    key_sell = ~keys[1];
    key_cancel = ~keys[2];
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (order_strobe) begin
        st_cnt++;
        if (st_first < 0) begin
          st_first = n;
          side_seen = order_side;
        end
      end
      if (reject) begin
        rj_cnt++;
        if (rj_first < 0) rj_first = n;
      end
      match_signal = (n == EXP_EDGE - 1) ? match : 1'b0;
      if (n == EXP_EDGE) sw = sw_after;
    end
    key_buy = 1'b1; key_sell = 1'b1; key_cancel = 1'b1;
    halt_signal = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic do_entry(input string tag, input logic [2:0] keys, input logic [7:0] price,
                          input logic halt, input logic match, input logic [7:0] sw_after,
                          input logic e_strobe, input logic e_reject, input logic e_side,
                          input logic e_bv, input logic e_sv,
                          input logic [7:0] e_bp, input logic [7:0] e_sp);
    int st_cnt, st_first, rj_cnt, rj_first;
    logic side_seen;
    run_entry(keys, price, halt, match, sw_after, st_cnt, st_first, rj_cnt, rj_first, side_seen);
    $display("entry %s keys=%b price=%0d halt=%0d match=%0d strobes=%0d rejects=%0d bv=%0d sv=%0d bp=%0d sp=%0d",
             tag, keys, price, halt, match, st_cnt, rj_cnt, buy_valid, sell_valid, buy_price, sell_price);
    check({tag, "_strobe_count"}, 32'(st_cnt), e_strobe ? 32'd1 : 32'd0);
    if (e_strobe) begin
      check({tag, "_strobe_edge"}, 32'(st_first), 32'(EXP_EDGE));
      check({tag, "_side"}, 32'(side_seen), 32'(e_side));
    end
    check({tag, "_reject_count"}, 32'(rj_cnt), e_reject ? 32'd1 : 32'd0);
    if (e_reject) check({tag, "_reject_edge"}, 32'(rj_first), 32'(EXP_EDGE));
    check({tag, "_buy_valid"}, 32'(buy_valid), 32'(e_bv));
    check({tag, "_sell_valid"}, 32'(sell_valid), 32'(e_sv));
    check({tag, "_buy_price"}, 32'(buy_price), 32'(e_bp));
    check({tag, "_sell_price"}, 32'(sell_price), 32'(e_sp));
  endtask

  // Book behaviour straight from the entry rules; updates the model and returns the outcome.
  function automatic void model_entry(input logic [2:0] keys, input logic [7:0] price,
                                      input logic halt, input logic match,
                                      output logic es, output logic er, output logic eside);
    es = 1'b0; er = 1'b0; eside = 1'b0;
    if (match) begin
      m_bv = 1'b0;
      m_sv = 1'b0;
    end
    if (keys[2]) begin
      m_bv = 1'b0;
      m_sv = 1'b0;
    end else if (keys[0] && keys[1]) begin
      er = 1'b1;
    end else if (halt || price > 8'd99) begin
      er = 1'b1;
    end else if (keys[0]) begin
      es = 1'b1; eside = 1'b0; m_bv = 1'b1; m_bp = price;
    end else begin
      es = 1'b1; eside = 1'b1; m_sv = 1'b1; m_sp = price;
    end
  endfunction

  initial begin
    int cnt;
    logic es, er, eside;

    vecs[0]  = '{3'b001, 8'd37,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd37, 8'd0};
    vecs[1]  = '{3'b010, 8'd120, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd37, 8'd0};
    vecs[2]  = '{3'b011, 8'd10,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd37, 8'd0};
    vecs[3]  = '{3'b101, 8'd55,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd37, 8'd0};
    vecs[4]  = '{3'b001, 8'd40,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd0};
    vecs[5]  = '{3'b010, 8'd45,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd40, 8'd45};
    vecs[6]  = '{3'b010, 8'd50,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd40, 8'd50};
    vecs[7]  = '{3'b010, 8'd99,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd40, 8'd50};
    vecs[8]  = '{3'b010, 8'd99,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd40, 8'd99};
    vecs[9]  = '{3'b001, 8'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd40, 8'd99};
    vecs[10] = '{3'b001, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,  8'd99};
    vecs[11] = '{3'b100, 8'd12,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd99};

    reset = 1'b1;
    sw = 8'd0;
    key_buy = 1'b1; key_sell = 1'b1; key_cancel = 1'b1;
    halt_signal = 1'b0; match_signal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("after_reset");

    for (int i = 0; i < 12; i++) begin
      do_entry($sformatf("vec%0d", i), vecs[i].keys, vecs[i].price, vecs[i].halt,
               vecs[i].match, vecs[i].price, vecs[i].e_strobe, vecs[i].e_reject,
               vecs[i].e_side, vecs[i].e_bv, vecs[i].e_sv, vecs[i].e_bp, vecs[i].e_sp);
    end

    // Bouncing key: 3 low, 1 high, repeated, never settles
    cnt = 0;
    @(posedge clk); #1;
    sw = 8'd77;
    for (int r = 0; r < 5; r++) begin
      key_buy = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        cnt += int'(order_strobe) + int'(reject);
      end
      key_buy = 1'b1;
      @(posedge clk); #1;
      cnt += int'(order_strobe) + int'(reject);
    end
    $display("bounce burst events=%0d", cnt);
    check("bounce_no_event", 32'(cnt), 32'd0);
    do_entry("bounce_hold", 3'b001, 8'd77, 1'b0, 1'b0, 8'd77,
             1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd77, 8'd99);

    // Reset while the FSM sits in COMMIT
    @(posedge clk); #1;
    sw = 8'd20;
    key_buy = 1'b0;
    repeat (EXP_EDGE - 1) @(posedge clk);
    #1;
    check("pre_reset_no_strobe", 32'(order_strobe), 32'd0);
    reset = 1'b1;
    key_buy = 1'b1;
    #1;
    check_outputs_zero("reset_in_commit");
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      cnt += int'(order_strobe) + int'(reject);
    end
    $display("reset in commit: events after reset=%0d", cnt);
    check("reset_drop_events", 32'(cnt), 32'd0);
    check_outputs_zero("post_reset_commit");

    // Randomized entries against the reference book
    m_bv = 1'b0; m_sv = 1'b0; m_bp = 8'd0; m_sp = 8'd0;
    for (int t = 0; t < 30; t++) begin
      logic [2:0] keys;
      logic [7:0] price;
      logic halt, match;
      keys  = 3'($urandom_range(1, 7));
      price = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255))
                                          : 8'($urandom_range(0, 99));
      halt  = ($urandom_range(0, 4) == 0);
      match = ($urandom_range(0, 3) == 0);
      model_entry(keys, price, halt, match, es, er, eside);
      do_entry($sformatf("rnd%0d", t), keys, price, halt, match, 8'($urandom),
               es, er, eside, m_bv, m_sv, m_bp, m_sp);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        match_signal = 1'b1;
        @(posedge clk); #1;
        match_signal = 1'b0;
        m_bv = 1'b0;
        m_sv = 1'b0;
        $display("idle match pulse bv=%0d sv=%0d", buy_valid, sell_valid);
        check($sformatf("rnd%0d_match_bv", t), 32'(buy_valid), 32'(m_bv));
        check($sformatf("rnd%0d_match_sv", t), 32'(sell_valid), 32'(m_sv));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
